// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the 16-way grant arbiter.
package rr_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int IDW   = 4;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDW-1:0]   req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : rr_arbiter_pkg

// File: rtl/find_first16.sv
// Combinational winner search: highest set bit (fixed) or first set bit
// at or above a start index with wrap-around (round-robin).
module find_first16
    import rr_arbiter_pkg::*;
(
    input  req_vec_t vec,
    input  req_id_t  start,
    input  logic     fixed_prio,
    output req_id_t  idx,
    output logic     found
);

    logic [2*N_REQ-1:0] dbl;
    req_vec_t           rot;

    // NOTE: every output gets a default before any conditional assignment,
    // so no path through the block leaves a value held (no latch).
    always_comb begin
        idx   = '0;
        found = |vec;
        // Doubled vector rotated so bit 0 of rot is position 'start'; the
        // wrap from 15 back to 0 falls out of the upper copy.
        dbl   = {vec, vec} >> start;
        rot   = dbl[N_REQ-1:0];
        if (fixed_prio) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (vec[i]) idx = req_id_t'(i);
            end
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (rot[i]) idx = start + req_id_t'(i);
            end
        end
    end

endmodule : find_first16

// File: rtl/rr_arbiter16.sv
// 16-requester arbiter: round-robin or fixed priority, grant held until
// done, request drop, or hold-timer expiry; re-arbitrates without a bubble.
module rr_arbiter16
    import rr_arbiter_pkg::req_id_t;
    import rr_arbiter_pkg::arb_state_t;
    import rr_arbiter_pkg::IDLE;
    import rr_arbiter_pkg::BUSY;
#(
    parameter int N        = rr_arbiter_pkg::N_REQ,
    parameter int IDW      = rr_arbiter_pkg::IDW,
    parameter int HOLD_MAX = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_i,
    input  logic           done_i,
    input  logic           mode_fixed_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic           gnt_valid_o
);

    localparam int CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    // With the timer disabled the counter simply saturates at all-ones.
    localparam logic [CW-1:0] HOLD_LIM = (HOLD_MAX == 0) ? '1 : CW'(HOLD_MAX);

    arb_state_t    state;
    req_id_t       ptr;
    logic [CW-1:0] hold_cnt;

    req_id_t start_id;
    req_id_t win_id;
    logic    win_found;
    logic    timeout;
    logic    release_now;
    logic    arb_point;

    assign start_id = ptr + req_id_t'(1);

    find_first16 u_find (
        .vec        (req_i),
        .start      (start_id),
        .fixed_prio (mode_fixed_i),
        .idx        (win_id),
        .found      (win_found)
    );

    assign timeout     = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIM);
    assign release_now = (state == BUSY) && (done_i || !req_i[gnt_id_o] || timeout);
    assign arb_point   = (state == IDLE) || release_now;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            gnt_valid_o <= 1'b0;
            ptr         <= req_id_t'(N - 1);
            hold_cnt    <= '0;
        end else if (arb_point) begin
            if (win_found) begin
                state       <= BUSY;
                gnt_o       <= {{(N-1){1'b0}}, 1'b1} << win_id;
                gnt_id_o    <= win_id;
                gnt_valid_o <= 1'b1;
                ptr         <= win_id;
                hold_cnt    <= CW'(1);
            end else begin
                // Pointer is kept so round-robin fairness survives idle gaps.
                state       <= IDLE;
                gnt_o       <= '0;
                gnt_id_o    <= '0;
                gnt_valid_o <= 1'b0;
                hold_cnt    <= '0;
            end
        end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + CW'(1);
        end
    end

endmodule : rr_arbiter16

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus a randomized
// run against a behavioural model of the grant rules.
module tb_rr_arbiter16;

    localparam int HOLD = 8;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic [15:0] req_i        = '0;
    logic        done_i       = 1'b0;
    logic        mode_fixed_i = 1'b0;
    logic [15:0] gnt_o;
    logic [3:0]  gnt_id_o;
    logic        gnt_valid_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_valid = 0;
    int m_id    = 0;
    int m_ptr   = 15;
    int m_hold  = 0;

    rr_arbiter16 #(.N(16), .IDW(4), .HOLD_MAX(HOLD)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .done_i       (done_i),
        .mode_fixed_i (mode_fixed_i),
        .gnt_o        (gnt_o),
        .gnt_id_o     (gnt_id_o),
        .gnt_valid_o  (gnt_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int pick(input logic [15:0] req, input logic fixed, input int ptr);
        if (fixed) begin
            for (int k = 15; k >= 0; k--) if (req[k]) return k;
        end else begin
            for (int off = 1; off <= 16; off++) if (req[(ptr + off) % 16]) return (ptr + off) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk_i) begin : model
        int w;
        bit rel;
        if (!rst_ni) begin
            m_valid = 0; m_id = 0; m_ptr = 15; m_hold = 0;
        end else begin
            rel = (m_valid != 0) && (done_i || !req_i[m_id] || (m_hold == HOLD));
            if (m_valid == 0 || rel) begin
                w = pick(req_i, mode_fixed_i, m_ptr);
                if (w >= 0) begin
                    m_valid = 1; m_id = w; m_ptr = w; m_hold = 1;
                end else begin
                    m_valid = 0; m_id = 0; m_hold = 0;
                end
            end else if (m_hold < HOLD) begin
                m_hold = m_hold + 1;
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0; req_i = '0; done_i = 1'b0; mode_fixed_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = 16'hFFFF; done_i = 1'b0; mode_fixed_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (gnt_o !== 16'h0 || gnt_id_o !== 4'd0 || gnt_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got gnt=%h id=%0d valid=%b, want 0/0/0", c, gnt_o, gnt_id_o, gnt_valid_o);
            end
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 16'h0001 || gnt_id_o !== 4'd0 || gnt_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got gnt=%h id=%0d valid=%b, want 0001/0/1", gnt_o, gnt_id_o, gnt_valid_o);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 2, 15, 0, 2};
        do_reset();
        req_i = 16'h8005; done_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'(exp_seq[c]) || gnt_o !== (16'h1 << exp_seq[c])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got id=%0d gnt=%h valid=%b, want id=%0d valid=1", c, gnt_id_o, gnt_o, gnt_valid_o, exp_seq[c]);
            end
        end
        done_i = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        mode_fixed_i = 1'b1; req_i = 16'h0012; done_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'd4 || gnt_o !== 16'h0010) begin
                errors++;
                $display("FAIL fixed_hi[%0d]: got id=%0d gnt=%h valid=%b, want id=4", c, gnt_id_o, gnt_o, gnt_valid_o);
            end
        end
        req_i = 16'h0002;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'd1 || gnt_o !== 16'h0002) begin
                errors++;
                $display("FAIL fixed_lo[%0d]: got id=%0d gnt=%h valid=%b, want id=1", c, gnt_id_o, gnt_o, gnt_valid_o);
            end
        end
        done_i = 1'b0; mode_fixed_i = 1'b0;
    endtask

    task automatic test_timeout();
        int exp_id;
        do_reset();
        req_i = 16'h0003;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk_i);
            exp_id = (c / HOLD) % 2;
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'(exp_id)) begin
                errors++;
                $display("FAIL timeout[%0d]: got id=%0d valid=%b, want id=%0d valid=1", c, gnt_id_o, gnt_valid_o, exp_id);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req_i = 16'h0008;
        @(negedge clk_i);
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'd3 || gnt_o !== 16'h0008) begin
            errors++;
            $display("FAIL drop_grant: got id=%0d gnt=%h valid=%b, want id=3", gnt_id_o, gnt_o, gnt_valid_o);
        end
        req_i = 16'h0000;
        @(negedge clk_i);
        checks++;
        if (gnt_valid_o !== 1'b0 || gnt_o !== 16'h0 || gnt_id_o !== 4'd0) begin
            errors++;
            $display("FAIL drop_idle: got id=%0d gnt=%h valid=%b, want 0/0/0", gnt_id_o, gnt_o, gnt_valid_o);
        end
        req_i = 16'h0008;
        @(negedge clk_i);
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_id_o !== 4'd3 || gnt_o !== 16'h0008) begin
            errors++;
            $display("FAIL drop_regrant: got id=%0d gnt=%h valid=%b, want id=3", gnt_id_o, gnt_o, gnt_valid_o);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_i = 16'h0020;
        repeat (4) @(negedge clk_i);
        checks++;
        if (gnt_id_o !== 4'd5 || gnt_valid_o !== 1'b1 || u_dut.hold_cnt !== 4'd4) begin
            errors++;
            $display("FAIL mid_pre: got id=%0d valid=%b hold=%0d, want id=5 hold=4", gnt_id_o, gnt_valid_o, u_dut.hold_cnt);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (gnt_o !== 16'h0 || gnt_id_o !== 4'd0 || gnt_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got gnt=%h id=%0d valid=%b, want 0/0/0", gnt_o, gnt_id_o, gnt_valid_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (gnt_id_o !== 4'd5 || gnt_o !== 16'h0020 || gnt_valid_o !== 1'b1 || u_dut.hold_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mid_regrant: got id=%0d gnt=%h valid=%b hold=%0d, want id=5 hold=1", gnt_id_o, gnt_o, gnt_valid_o, u_dut.hold_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req_i = 16'h0;
                    1: req_i = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    2: req_i = 16'($urandom);
                    default: req_i = 16'($urandom) | 16'($urandom);
                endcase
            end
            done_i = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) mode_fixed_i = ~mode_fixed_i;
            rst_ni = ($urandom_range(0, 149) != 0);
            @(negedge clk_i);
            exp_gnt = (m_valid != 0) ? (16'h1 << m_id) : 16'h0;
            checks++;
            if (gnt_o !== exp_gnt || gnt_id_o !== 4'(m_id) || gnt_valid_o !== (m_valid != 0)
                || u_dut.hold_cnt !== 4'(m_hold)) begin
                errors++;
                $display("FAIL random[%0d]: got gnt=%h id=%0d valid=%b hold=%0d, want gnt=%h id=%0d valid=%0d hold=%0d",
                         c, gnt_o, gnt_id_o, gnt_valid_o, u_dut.hold_cnt, exp_gnt, m_id, m_valid, m_hold);
            end
        end
        rst_ni = 1'b1; done_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed();
        test_timeout();
        test_req_drop();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_arbiter16

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Sequential arbiter that shares one downstream resource among 16 requesters.
- Each cycle it picks one requester in either round-robin or fixed-priority mode, then holds that grant until the transaction ends.
- A hold timer limits how long one grant can last, so no requester starves.
- Sits between the requester bank and the shared datapath; gnt_id_o drives the datapath mux select.

Parameters:
- N, 16, number of requesters; the RTL supports only 16.
- IDW, 4, width of the grant index (log2 N).
- HOLD_MAX, 8, maximum number of cycles a grant lasts before forced release; 0 disables the timer.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- req_i  in  16  request vector; bit k = requester k wants the resource.
- done_i  in  1  pulse from the current grantee: its transaction ends this cycle.
- mode_fixed_i  in  1  arbitration mode: 1 = fixed priority (highest index wins), 0 = round-robin.
- gnt_o  out  16  one-hot grant vector.
- gnt_id_o  out  4  binary index of the grantee.
- gnt_valid_o  out  1  a grant is active.

Behaviour:
- Reset (rst_ni low at a rising edge):
  - gnt_o=0, gnt_id_o=0, gnt_valid_o=0, state=IDLE, hold_cnt=0, ptr=15.
  - A reset while a grant is active drops the grant at that same edge; no completion is required.
- States:
  - IDLE: no grant active.
  - BUSY: grant held.
- Arbitration point: any cycle in IDLE, or a BUSY cycle that ends in release.
  - Combinational winner W is computed from req_i.
  - mode_fixed_i is sampled only at arbitration points.
- Fixed mode: W is the highest set bit of req_i.
- Round-robin mode: W is the first set bit searching upward from ptr+1, wrapping 15 to 0. ptr itself is checked last.
- IDLE to BUSY:
  - If req_i != 0, the registered outputs update at the next edge: gnt_o=1<<W, gnt_id_o=W, gnt_valid_o=1, ptr=W, hold_cnt=1.
  - Latency from request to grant is 1 cycle.
- Release conditions while BUSY, any one suffices:
  - done_i=1;
  - req_i[gnt_id_o]=0;
  - HOLD_MAX!=0 and hold_cnt==HOLD_MAX.
- On release, re-arbitrate in the same cycle:
  - If a winner exists, the next cycle switches directly to the new grant with no bubble. hold_cnt=1 and ptr=W.
  - The winner may be the current grantee if it is still requesting: its own done/timeout does not mask it. In round-robin it is checked last.
  - If no winner exists, the next cycle is IDLE with all outputs 0. gnt_id_o returns to 0 and ptr is kept.
- Without release: outputs hold and hold_cnt increments, saturating at HOLD_MAX.
- Simultaneous events:
  - done_i together with a deasserted request counts as a single release.
  - done_i in IDLE is ignored.
  - Changes on non-granted req_i bits never disturb an active grant.
- Invariants:
  - gnt_o is always one-hot or zero.
  - gnt_o==0 if and only if gnt_valid_o==0.
  - gnt_id_o always matches gnt_o.

Decomposition:
- Package rr_arbiter_pkg holds:
  - N_REQ=16 and IDW=4;
  - typedef req_vec_t (logic [15:0]) and typedef req_id_t (logic [3:0]);
  - enum arb_state_t {IDLE, BUSY}.
- Sub-module find_first16:
  - Combinational.
  - Inputs: 16-bit vector, start index, direction/wrap control.
  - Outputs: index and found flag.
  - Instantiated once; the round-robin rotation uses a doubled-vector mask inside it.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with req_i=16'hFFFF -> all outputs 0 throughout. Raise rst_ni in cycle 3 -> gnt_id_o=0, gnt_o=16'h0001, gnt_valid_o=1 from cycle 4 (ptr 15 wraps to index 0).
- Round-robin: mode_fixed_i=0, req_i=16'h8005 held, done_i pulsed on every grant cycle -> grant sequence 0, 2, 15, 0, 2 with no idle cycles between grants.
- Fixed priority: mode_fixed_i=1, req_i=16'h0012, done_i pulsed each grant -> gnt_id_o=4 on every grant. Clear bit 4 (req_i=16'h0002) -> next grant is id 1.
- Timeout: HOLD_MAX=8, req_i=16'h0003, done_i=0 -> id 0 for exactly 8 cycles, then id 1 for 8 cycles, then id 0, with no bubble at each switch.
- Request drop: grant active on id 3, then req_i goes from 16'h0008 to 0 -> gnt_valid_o=0 and gnt_o=0 next cycle. Re-assert 16'h0008 -> id 3 re-granted 1 cycle later.
- Reset mid-grant: while id 5 is granted with hold_cnt=4, pull rst_ni low for one edge -> outputs 0 at that edge. With req_i=16'h0020 still asserted after reset release -> id 5 re-granted one cycle after rst_ni returns high, with hold_cnt=1.
